// File: rtl/tone_oscillator.sv
// Tone oscillator: turns a note period (in hz12M cycles) into an 8-bit square/saw/triangle
// sample with a per-phase-step strobe; period changes are deferred to the period boundary.
module tone_oscillator #(
   parameter int DIV_W    = 16,
   parameter int SAMPLE_W = 8,
   parameter int MIN_DIV  = 256
) (
   input  logic                hz12M,
   input  logic                reset,
   input  logic                en,
   input  logic [DIV_W-1:0]    divider,
   input  logic [1:0]          wave_sel,
   output logic [SAMPLE_W-1:0] sample,
   output logic                sample_stb,
   output logic                note_active
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [DIV_W-1:0]    MIN_DIV_V = DIV_W'(MIN_DIV);
   localparam logic [DIV_W-1:0]    CNT_ONE   = DIV_W'(1);
   localparam logic [SAMPLE_W-1:0] PH_ONE    = SAMPLE_W'(1);
   localparam logic [SAMPLE_W-1:0] PH_MAX    = {SAMPLE_W{1'b1}};

   state_t              state_q, state_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [DIV_W-1:0]    cnt_q, cnt_d;
   logic [SAMPLE_W-1:0] pre_q, pre_d;
   logic [SAMPLE_W-1:0] phase_q, phase_d;
   logic                stb_q, stb_d;

   logic [SAMPLE_W-1:0] step_len;
   logic                div_ok;
   logic                wrap;
   logic                step_done;

   function automatic logic [SAMPLE_W-1:0] phase_sat_inc(input logic [SAMPLE_W-1:0] p);
      return (p == PH_MAX) ? p : p + PH_ONE;
   endfunction

   function automatic logic [SAMPLE_W-1:0] tri_fold(input logic [SAMPLE_W-1:0] p);
      logic [SAMPLE_W-1:0] ramp;
      ramp = {p[SAMPLE_W-2:0], 1'b0};
      return p[SAMPLE_W-1] ? ~ramp : ramp;
   endfunction

   // Top bits of the period give the per-step length; MIN_DIV guarantees it is at least 1.
   assign step_len  = div_q[DIV_W-1 -: SAMPLE_W];
   assign div_ok    = (divider >= MIN_DIV_V);
   assign wrap      = (cnt_q == div_q - CNT_ONE);
   assign step_done = (pre_q == step_len - PH_ONE);

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      pre_d   = pre_q;
      phase_d = phase_q;
      stb_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d   = '0;
            pre_d   = '0;
            phase_d = '0;
            if (en && div_ok) begin
               div_d   = divider;
               state_d = RUN;
            end
         end
         RUN: begin
            if (!en) begin
               state_d = IDLE;
               cnt_d   = '0;
               pre_d   = '0;
               phase_d = '0;
            end else if (wrap) begin
               cnt_d   = '0;
               pre_d   = '0;
               phase_d = '0;
               stb_d   = 1'b1;
               if (div_ok) div_d = divider;
               else        state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
               if (step_done) begin
                  pre_d   = '0;
                  phase_d = phase_sat_inc(phase_q);
                  stb_d   = (phase_d != phase_q);
               end else begin
                  pre_d = pre_q + PH_ONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge hz12M or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         pre_q   <= '0;
         phase_q <= '0;
         stb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         pre_q   <= pre_d;
         phase_q <= phase_d;
         stb_q   <= stb_d;
      end
   end

   // Waveform select is purely combinational so it can change any cycle without touching counters.
   always_comb begin
      sample = '0;
      if (state_q == RUN) begin
         unique case (wave_sel)
            2'b01:   sample = phase_q;
            2'b10:   sample = tri_fold(phase_q);
            default: sample = (cnt_q < (div_q >> 1)) ? PH_MAX : '0;
         endcase
      end
   end

   assign sample_stb  = stb_q;
   assign note_active = (state_q == RUN);

endmodule

// File: tb/tb_tone_oscillator.sv
// Bench for tone_oscillator: random and directed notes checked against a period-offset model.
module tb_tone_oscillator;

   logic        hz12M = 1'b0;
   logic        reset;
   logic        en;
   logic [15:0] divider;
   logic [1:0]  wave_sel;
   logic [7:0]  sample;
   logic        sample_stb;
   logic        note_active;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 hz12M = ~hz12M;

   tone_oscillator dut (
      .hz12M       (hz12M),
      .reset       (reset),
      .en          (en),
      .divider     (divider),
      .wave_sel    (wave_sel),
      .sample      (sample),
      .sample_stb  (sample_stb),
      .note_active (note_active)
   );

   // Reference: a note is a running flag, its period D and the offset t inside the period.
   logic m_run;
   int   m_D;
   int   m_t;
   logic m_stb;

   always @(posedge hz12M or posedge reset) begin
      if (reset) begin
         m_run <= 1'b0; m_D <= 0; m_t <= 0; m_stb <= 1'b0;
      end else if (!m_run) begin
         m_t <= 0; m_stb <= 1'b0;
         if (en && int'(divider) >= 256) begin
            m_run <= 1'b1; m_D <= int'(divider);
         end
      end else if (!en) begin
         m_run <= 1'b0; m_t <= 0; m_stb <= 1'b0;
      end else if (m_t == m_D - 1) begin
         m_t <= 0; m_stb <= 1'b1;
         if (int'(divider) >= 256) m_D <= int'(divider);
         else                      m_run <= 1'b0;
      end else begin
         m_t   <= m_t + 1;
         m_stb <= ((m_t + 1) % (m_D / 256) == 0) && ((m_t + 1) / (m_D / 256) <= 255);
      end
   end

   function automatic logic [7:0] exp_sample(input logic run, input int D, input int t,
                                             input logic [1:0] ws);
      int ph;
      if (!run) return 8'h00;
      ph = t / (D / 256);
      if (ph > 255) ph = 255;
      case (ws)
         2'b01:   return 8'(ph);
         2'b10:   return (ph < 128) ? 8'(2 * ph) : 8'(255 - 2 * (ph - 128));
         default: return (t < D / 2) ? 8'hFF : 8'h00;
      endcase
   endfunction

   task automatic test_reset();
      reset = 1'b1; en = 1'b0; divider = 16'd0; wave_sel = 2'b00;
      repeat (3) @(negedge hz12M);
      n_tests++;
      if (sample !== 8'h00) begin n_fail++; $display("FAIL rst_sample got %h exp 00", sample); end
      n_tests++;
      if (sample_stb !== 1'b0) begin n_fail++; $display("FAIL rst_stb got %b exp 0", sample_stb); end
      n_tests++;
      if (note_active !== 1'b0) begin n_fail++; $display("FAIL rst_active got %b exp 0", note_active); end
      reset = 1'b0;
   endtask

   task automatic test_silence();
      en = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge hz12M);
         divider  = (c < 30) ? 16'd1 : 16'($urandom_range(0, 255));
         wave_sel = 2'($urandom_range(0, 3));
         #1;
         n_tests++;
         if (note_active !== 1'b0) begin n_fail++; $display("FAIL sil_active c=%0d got %b exp 0", c, note_active); end
         n_tests++;
         if (sample !== 8'h00) begin n_fail++; $display("FAIL sil_sample c=%0d got %h exp 00", c, sample); end
         n_tests++;
         if (sample_stb !== 1'b0) begin n_fail++; $display("FAIL sil_stb c=%0d got %b exp 0", c, sample_stb); end
      end
      en = 1'b0;
      @(negedge hz12M);
   endtask

   // 45868 square period with a mid-period divider change, then one 22933 period with
   // random waveforms (triangle peaks forced), ending in silence at the wrap.
   task automatic test_period_change();
      int         lm_c [10];
      logic [1:0] lm_w [10];
      logic [7:0] lm_v [10];
      logic [1:0] ws;
      int         lm;
      lm_c = '{0, 22933, 22934, 45867, 45868, 45868 + 11303, 45868 + 11392,
               45868 + 11465, 45868 + 11466, 45868 + 22932};
      lm_w = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1};
      lm_v = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFE, 8'hFF, 8'hFF, 8'h00, 8'hFF};
      @(negedge hz12M);
      en = 1'b1; divider = 16'd45868; wave_sel = 2'b00;
      for (int c = 0; c < 68804; c++) begin
         @(negedge hz12M);
         ws = (c < 45868) ? 2'b00 : 2'($urandom_range(0, 3));
         lm = -1;
         for (int i = 0; i < 10; i++) if (lm_c[i] == c) lm = i;
         if (lm >= 0) ws = lm_w[lm];
         wave_sel = ws;
         #1;
         n_tests++;
         if (sample !== exp_sample(m_run, m_D, m_t, wave_sel)) begin
            n_fail++;
            $display("FAIL chg_sample c=%0d got %h exp %h", c, sample, exp_sample(m_run, m_D, m_t, wave_sel));
         end
         n_tests++;
         if (sample_stb !== m_stb) begin n_fail++; $display("FAIL chg_stb c=%0d got %b exp %b", c, sample_stb, m_stb); end
         n_tests++;
         if (note_active !== m_run) begin n_fail++; $display("FAIL chg_active c=%0d got %b exp %b", c, note_active, m_run); end
         if (lm >= 0) begin
            n_tests++;
            if (sample !== lm_v[lm]) begin n_fail++; $display("FAIL chg_landmark c=%0d got %h exp %h", c, sample, lm_v[lm]); end
            n_tests++;
            if (note_active !== 1'b1) begin n_fail++; $display("FAIL chg_lm_active c=%0d got %b exp 1", c, note_active); end
         end
         if (c == 45868) begin
            n_tests++;
            if (sample_stb !== 1'b1) begin n_fail++; $display("FAIL chg_wrap_stb got %b exp 1", sample_stb); end
         end
         if (c == 68801) begin
            n_tests++;
            if (note_active !== 1'b0 || sample !== 8'h00) begin
               n_fail++; $display("FAIL chg_to_idle active %b sample %h exp 0/00", note_active, sample);
            end
         end
         if (c == 1000) divider = 16'd22933;
         if (c == 45868 + 100) divider = 16'd1;
      end
      en = 1'b0;
      @(negedge hz12M);
   endtask

   task automatic test_sawtooth_strobes();
      int D, sl, nstb;
      D = $urandom_range(1024, 4095);
      sl = D / 256;
      nstb = 0;
      @(negedge hz12M);
      en = 1'b1; divider = 16'(D); wave_sel = 2'b01;
      for (int c = 0; c <= D + 1; c++) begin
         @(negedge hz12M);
         #1;
         n_tests++;
         if (sample !== exp_sample(m_run, m_D, m_t, wave_sel)) begin
            n_fail++;
            $display("FAIL saw_sample c=%0d got %h exp %h", c, sample, exp_sample(m_run, m_D, m_t, wave_sel));
         end
         n_tests++;
         if (sample_stb !== m_stb) begin n_fail++; $display("FAIL saw_stb c=%0d got %b exp %b", c, sample_stb, m_stb); end
         if (c >= 1 && c <= D && sample_stb === 1'b1) nstb++;
         if (c == sl - 1 || c == D) begin
            n_tests++;
            if (sample !== 8'h00) begin n_fail++; $display("FAIL saw_zero c=%0d got %h exp 00", c, sample); end
         end
         if (c == sl) begin
            n_tests++;
            if (sample !== 8'h01 || sample_stb !== 1'b1) begin
               n_fail++; $display("FAIL saw_first_step c=%0d got %h/%b exp 01/1", c, sample, sample_stb);
            end
         end
         if (c == 255 * sl || c == D - 1) begin
            n_tests++;
            if (sample !== 8'hFF) begin n_fail++; $display("FAIL saw_top c=%0d got %h exp ff", c, sample); end
         end
      end
      n_tests++;
      if (nstb != 256) begin n_fail++; $display("FAIL saw_stb_count D=%0d got %0d exp 256", D, nstb); end
      en = 1'b0;
      @(negedge hz12M);
   endtask

   task automatic test_reset_and_en_midnote();
      int D, sl;
      D = $urandom_range(6000, 8000);
      sl = D / 256;
      @(negedge hz12M);
      en = 1'b1; divider = 16'(D); wave_sel = 2'b00;
      for (int c = 0; c <= 5000; c++) begin
         @(negedge hz12M);
         #1;
         n_tests++;
         if (sample !== exp_sample(m_run, m_D, m_t, wave_sel) || note_active !== m_run) begin
            n_fail++;
            $display("FAIL mid_run c=%0d got %h/%b exp %h/%b", c, sample, note_active,
                     exp_sample(m_run, m_D, m_t, wave_sel), m_run);
         end
      end
      reset = 1'b1;
      #1;
      n_tests++;
      if (sample !== 8'h00 || note_active !== 1'b0 || sample_stb !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset got %h/%b/%b exp 00/0/0", sample, note_active, sample_stb);
      end
      @(negedge hz12M);
      reset = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge hz12M);
         #1;
         n_tests++;
         if (sample !== exp_sample(m_run, m_D, m_t, wave_sel) || note_active !== m_run || sample_stb !== m_stb) begin
            n_fail++;
            $display("FAIL restart c=%0d got %h/%b/%b exp %h/%b/%b", c, sample, note_active, sample_stb,
                     exp_sample(m_run, m_D, m_t, wave_sel), m_run, m_stb);
         end
         if (c == 0) begin
            n_tests++;
            if (sample !== 8'hFF || note_active !== 1'b1) begin
               n_fail++; $display("FAIL restart_first got %h/%b exp ff/1", sample, note_active);
            end
         end
      end
      en = 1'b0;
      #1;
      n_tests++;
      if (note_active !== 1'b1) begin n_fail++; $display("FAIL en_drop_same_cycle got %b exp 1", note_active); end
      @(negedge hz12M);
      n_tests++;
      if (note_active !== 1'b0 || sample !== 8'h00) begin
         n_fail++; $display("FAIL en_drop_next got %b/%h exp 0/00", note_active, sample);
      end
      wave_sel = 2'b01; en = 1'b1;
      for (int c = 0; c <= sl + 1; c++) begin
         @(negedge hz12M);
         #1;
         n_tests++;
         if (sample !== exp_sample(m_run, m_D, m_t, wave_sel) || note_active !== m_run) begin
            n_fail++;
            $display("FAIL reen c=%0d got %h/%b exp %h/%b", c, sample, note_active,
                     exp_sample(m_run, m_D, m_t, wave_sel), m_run);
         end
         if (c == 0 || c == sl - 1) begin
            n_tests++;
            if (sample !== 8'h00 || note_active !== 1'b1) begin
               n_fail++; $display("FAIL reen_phase0 c=%0d got %h/%b exp 00/1", c, sample, note_active);
            end
         end
         if (c == sl) begin
            n_tests++;
            if (sample !== 8'h01) begin n_fail++; $display("FAIL reen_step c=%0d got %h exp 01", c, sample); end
         end
      end
      en = 1'b0;
      @(negedge hz12M);
   endtask

   task automatic test_back_to_back();
      @(negedge hz12M);
      en = 1'b1; divider = 16'($urandom_range(256, 1200)); wave_sel = 2'($urandom_range(0, 3));
      for (int c = 0; c < 4000; c++) begin
         @(negedge hz12M);
         if ($urandom_range(0, 3) == 0) wave_sel = 2'($urandom_range(0, 3));
         #1;
         n_tests++;
         if (sample !== exp_sample(m_run, m_D, m_t, wave_sel)) begin
            n_fail++;
            $display("FAIL b2b_sample c=%0d got %h exp %h", c, sample, exp_sample(m_run, m_D, m_t, wave_sel));
         end
         n_tests++;
         if (sample_stb !== m_stb) begin n_fail++; $display("FAIL b2b_stb c=%0d got %b exp %b", c, sample_stb, m_stb); end
         n_tests++;
         if (note_active !== m_run) begin n_fail++; $display("FAIL b2b_active c=%0d got %b exp %b", c, note_active, m_run); end
         if ($urandom_range(0, 199) == 0) en = ~en;
         if ($urandom_range(0, 49) == 0) begin
            if ($urandom_range(0, 7) == 0) divider = 16'($urandom_range(0, 255));
            else                           divider = 16'($urandom_range(256, 1200));
         end
      end
      en = 1'b0;
      @(negedge hz12M);
   endtask

   initial begin
      test_reset();
      test_silence();
      test_period_change();
      test_sawtooth_strobes();
      test_reset_and_en_midnote();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
